// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, instruction memory and a registered IF/ID packet.
// Two-word instructions (opcode + immediate) are assembled into one packet by a small FSM.
module fetch_unit #(
  parameter int                   ADDR_W       = 32,
  parameter int                   INSTR_W      = 16,
  parameter int                   DEPTH_LOG2   = 19,
  parameter logic [ADDR_W-1:0]    RESET_VECTOR = ADDR_W'(32),
  parameter logic [INSTR_W-1:0]   NOP_WORD     = INSTR_W'(16'h4000),
  parameter int                   IMM_BIT      = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  redirect,
  input  logic [ADDR_W-1:0]     redirect_pc,
  input  logic                  imem_we,
  input  logic [DEPTH_LOG2-1:0] imem_waddr,
  input  logic [INSTR_W-1:0]    imem_wdata,
  output logic                  out_valid,
  output logic [INSTR_W-1:0]    instruction,
  output logic [INSTR_W-1:0]    immediate,
  output logic                  has_imm,
  output logic [ADDR_W-1:0]     pc_plus_n
);

  typedef enum logic {FETCH = 1'b0, FETCH_IMM = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d, hold_pc_q, hold_pc_d, pcn_q, pcn_d, pc_inc;
  logic [INSTR_W-1:0]   hold_q, hold_d, instr_q, instr_d, imm_q, imm_d, word;
  logic                 vld_q, vld_d, himm_q, himm_d;

  logic [INSTR_W-1:0]   mem [1<<DEPTH_LOG2];

  // Read is asynchronous, so a same-cycle write to the fetched entry is seen only on refetch.
  always_ff @(posedge clk) begin
    if (imem_we) mem[imem_waddr] <= imem_wdata;
  end

  assign word   = mem[pc_q[DEPTH_LOG2-1:0]];
  assign pc_inc = pc_q + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect || flush) begin
      state_d = FETCH;
    end else if (!stall) begin
      case (state_q)
        FETCH:     if (word[IMM_BIT]) state_d = FETCH_IMM;
        FETCH_IMM: state_d = FETCH;
      endcase
    end
  end

  always_comb begin
    pc_d      = pc_q;
    hold_d    = hold_q;
    hold_pc_d = hold_pc_q;
    vld_d     = vld_q;
    instr_d   = instr_q;
    imm_d     = imm_q;
    himm_d    = himm_q;
    pcn_d     = pcn_q;
    if (redirect || flush) begin
      vld_d   = 1'b0;
      instr_d = NOP_WORD;
      imm_d   = '0;
      himm_d  = 1'b0;
      if (redirect) begin
        pc_d   = redirect_pc;
        hold_d = '0;
      end else if (state_q == FETCH_IMM) begin
        // Abort the half-fetched pair and restart it from its opcode word.
        pc_d = hold_pc_q;
      end
    end else if (!stall) begin
      pc_d = pc_inc;
      case (state_q)
        FETCH: begin
          if (word[IMM_BIT]) begin
            hold_d    = word;
            hold_pc_d = pc_q;
            vld_d     = 1'b0;
            instr_d   = NOP_WORD;
            imm_d     = '0;
            himm_d    = 1'b0;
          end else begin
            vld_d     = 1'b1;
            instr_d   = word;
            imm_d     = '0;
            himm_d    = 1'b0;
            pcn_d     = pc_inc;
          end
        end
        FETCH_IMM: begin
          vld_d   = 1'b1;
          instr_d = hold_q;
          imm_d   = word;
          himm_d  = 1'b1;
          pcn_d   = pc_inc;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q      <= RESET_VECTOR;
      hold_q    <= '0;
      hold_pc_q <= '0;
      vld_q     <= 1'b0;
      instr_q   <= NOP_WORD;
      imm_q     <= '0;
      himm_q    <= 1'b0;
      pcn_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      hold_q    <= hold_d;
      hold_pc_q <= hold_pc_d;
      vld_q     <= vld_d;
      instr_q   <= instr_d;
      imm_q     <= imm_d;
      himm_q    <= himm_d;
      pcn_q     <= pcn_d;
    end
  end

  assign out_valid   = vld_q;
  assign instruction = instr_q;
  assign immediate   = imm_q;
  assign has_imm     = himm_q;
  assign pc_plus_n   = pcn_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected packets are queued per step and checked after the edge.
module tb_fetch_unit;

  typedef struct packed {
    logic        v;
    logic [15:0] ins;
    logic [15:0] imm;
    logic        hi;
    logic [31:0] pn;
    logic        chk_pn;
  } pkt_t;

  logic clk;
  // Full-size instance
  logic        reset, stall, flush, redirect, we;
  logic [31:0] rpc;
  logic [18:0] waddr;
  logic [15:0] wdata;
  logic        ov;
  logic [15:0] oins, oimm;
  logic        ohi;
  logic [31:0] opn;
  // 16-entry instance for wrap-around
  logic        s_reset, s_stall, s_flush, s_redirect, s_we;
  logic [31:0] s_rpc;
  logic [3:0]  s_waddr;
  logic [15:0] s_wdata;
  logic        s_ov;
  logic [15:0] s_oins, s_oimm;
  logic        s_ohi;
  logic [31:0] s_opn;

  int vectors = 0;
  int miss = 0;
  pkt_t sbq[$];

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .redirect(redirect),
    .redirect_pc(rpc), .imem_we(we), .imem_waddr(waddr), .imem_wdata(wdata),
    .out_valid(ov), .instruction(oins), .immediate(oimm), .has_imm(ohi), .pc_plus_n(opn)
  );

  fetch_unit #(.DEPTH_LOG2(4)) dut4 (
    .clk(clk), .reset(s_reset), .stall(s_stall), .flush(s_flush), .redirect(s_redirect),
    .redirect_pc(s_rpc), .imem_we(s_we), .imem_waddr(s_waddr), .imem_wdata(s_wdata),
    .out_valid(s_ov), .instruction(s_oins), .immediate(s_oimm), .has_imm(s_ohi), .pc_plus_n(s_opn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pkt_t R();
    return '{v:1'b0, ins:16'h4000, imm:16'h0, hi:1'b0, pn:32'd0, chk_pn:1'b1};
  endfunction
  function automatic pkt_t B();
    return '{v:1'b0, ins:16'h4000, imm:16'h0, hi:1'b0, pn:32'd0, chk_pn:1'b0};
  endfunction
  function automatic pkt_t K(input logic [15:0] ins, input logic [15:0] imm,
                             input logic hi, input logic [31:0] pn);
    return '{v:1'b1, ins:ins, imm:imm, hi:hi, pn:pn, chk_pn:1'b1};
  endfunction

  task automatic step(input pkt_t e, input bit sm, input string tag);
    pkt_t x, a;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    if (sm) a = '{v:s_ov, ins:s_oins, imm:s_oimm, hi:s_ohi, pn:s_opn, chk_pn:1'b0};
    else    a = '{v:ov,   ins:oins,   imm:oimm,   hi:ohi,   pn:opn,   chk_pn:1'b0};
    vectors++;
    assert (a.v === x.v) else begin
      miss++; $error("FAIL %s out_valid observed=%0h expected=%0h", tag, a.v, x.v);
    end
    vectors++;
    assert (a.ins === x.ins) else begin
      miss++; $error("FAIL %s instruction observed=%h expected=%h", tag, a.ins, x.ins);
    end
    vectors++;
    assert (a.imm === x.imm) else begin
      miss++; $error("FAIL %s immediate observed=%h expected=%h", tag, a.imm, x.imm);
    end
    vectors++;
    assert (a.hi === x.hi) else begin
      miss++; $error("FAIL %s has_imm observed=%0h expected=%0h", tag, a.hi, x.hi);
    end
    if (x.chk_pn) begin
      vectors++;
      assert (a.pn === x.pn) else begin
        miss++; $error("FAIL %s pc_plus_n observed=%0d expected=%0d", tag, a.pn, x.pn);
      end
    end
  endtask

  task automatic wr(input logic [18:0] a, input logic [15:0] d);
    we = 1'b1; waddr = a; wdata = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic swr(input logic [3:0] a, input logic [15:0] d);
    s_we = 1'b1; s_waddr = a; s_wdata = d;
    @(posedge clk); #1;
    s_we = 1'b0;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; we = 1'b0;
    rpc = '0; waddr = '0; wdata = '0;
    s_reset = 1'b0; s_stall = 1'b0; s_flush = 1'b0; s_redirect = 1'b0; s_we = 1'b0;
    s_rpc = '0; s_waddr = '0; s_wdata = '0;

    // Reset state and first fetch at the reset vector
    wr(19'd32, 16'h1234);
    step(R(), 0, "rst0");
    step(R(), 0, "rst1");
    reset = 1'b1;
    step(K(16'h1234, 16'h0, 1'b0, 32'd33), 0, "first");
    reset = 1'b0;
    step(R(), 0, "rst2");

    // Program image, loaded under reset
    wr(19'd32,  16'h8001); wr(19'd33, 16'hBEEF); wr(19'd34, 16'h0002); wr(19'd35, 16'h0003);
    wr(19'd100, 16'h0064);
    wr(19'd40,  16'h8055); wr(19'd41, 16'hCAFE); wr(19'd42, 16'h0042); wr(19'd43, 16'h0043);

    // Two-word pair
    reset = 1'b1;
    step(B(), 0, "pair_bub");
    step(K(16'h8001, 16'hBEEF, 1'b1, 32'd34), 0, "pair");
    step(K(16'h0002, 16'h0,    1'b0, 32'd35), 0, "after_pair");

    // Stall with a valid packet held
    stall = 1'b1;
    step(K(16'h0002, 16'h0, 1'b0, 32'd35), 0, "stall_v0");
    step(K(16'h0002, 16'h0, 1'b0, 32'd35), 0, "stall_v1");
    stall = 1'b0;
    step(K(16'h0003, 16'h0, 1'b0, 32'd36), 0, "stall_rel");

    // Stall three cycles in FETCH_IMM
    redirect = 1'b1; rpc = 32'd32;
    step(B(), 0, "redir32");
    redirect = 1'b0;
    step(B(), 0, "pair2_bub");
    stall = 1'b1;
    step(B(), 0, "stall_imm0");
    step(B(), 0, "stall_imm1");
    step(B(), 0, "stall_imm2");
    stall = 1'b0;
    step(K(16'h8001, 16'hBEEF, 1'b1, 32'd34), 0, "stall_pair");
    step(K(16'h0002, 16'h0,    1'b0, 32'd35), 0, "stall_next");

    // Redirect overrides stall and flush
    redirect = 1'b1; stall = 1'b1; flush = 1'b1; rpc = 32'd100;
    step(B(), 0, "redir_all");
    redirect = 1'b0; stall = 1'b0; flush = 1'b0;
    step(K(16'h0064, 16'h0, 1'b0, 32'd101), 0, "redir_tgt");

    // Flush inside FETCH_IMM refetches the pair from its first word
    redirect = 1'b1; rpc = 32'd40;
    step(B(), 0, "redir40");
    redirect = 1'b0;
    step(B(), 0, "p40_bub");
    flush = 1'b1;
    step(B(), 0, "flush_imm");
    flush = 1'b0;
    step(B(), 0, "p40_rebub");
    step(K(16'h8055, 16'hCAFE, 1'b1, 32'd42), 0, "p40_pair");
    step(K(16'h0042, 16'h0,    1'b0, 32'd43), 0, "p40_next");
    // Flush in FETCH refetches the current word
    flush = 1'b1;
    step(B(), 0, "flush_fetch");
    flush = 1'b0;
    step(K(16'h0043, 16'h0, 1'b0, 32'd44), 0, "refetch43");

    // Reset mid-pair discards the held word
    redirect = 1'b1; rpc = 32'd40;
    step(B(), 0, "redir40b");
    redirect = 1'b0;
    step(B(), 0, "p40b_bub");
    reset = 1'b0;
    step(R(), 0, "rst_mid");
    reset = 1'b1;
    step(B(), 0, "rst_pair_bub");
    step(K(16'h8001, 16'hBEEF, 1'b1, 32'd34), 0, "rst_pair");
    reset = 1'b0;

    // 16-entry instance: pair at last entry wraps, and write/fetch collision
    swr(4'd15, 16'h8000); swr(4'd0, 16'h00AA); swr(4'd1, 16'h0011); swr(4'd2, 16'h0022);
    step(R(), 1, "s_rst");
    s_reset = 1'b1; s_redirect = 1'b1; s_rpc = 32'd15;
    step(B(), 1, "s_redir15");
    s_redirect = 1'b0;
    step(B(), 1, "s_wrap_bub");
    step(K(16'h8000, 16'h00AA, 1'b1, 32'd17), 1, "s_wrap");
    step(K(16'h0011, 16'h0,    1'b0, 32'd18), 1, "s_w1");
    s_we = 1'b1; s_waddr = 4'd2; s_wdata = 16'h0033;
    step(K(16'h0022, 16'h0,    1'b0, 32'd19), 1, "s_old");
    s_we = 1'b0;
    s_redirect = 1'b1; s_rpc = 32'd18;
    step(B(), 1, "s_redir18");
    s_redirect = 1'b0;
    step(K(16'h0033, 16'h0,    1'b0, 32'd19), 1, "s_new");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch stage and successor to the single-word fetch block. It holds the PC and the instruction memory and presents a registered IF/ID bundle to decode. It adds stall, flush and branch redirect, and a two-state FSM that assembles two-word instructions (opcode word plus immediate word) into one decode packet. A load port lets the bench and boot logic fill instruction memory.

Parameters:
ADDR_W, 32, PC width in bits.
INSTR_W, 16, instruction/immediate word width.
DEPTH_LOG2, 19, log2 of instruction-memory entries.
RESET_VECTOR, 32, PC value after reset (entries below it are interrupt vectors).
NOP_WORD, 16'h4000, encoding driven on instruction when no valid instruction is presented.
IMM_BIT, 15, bit of the first word that, when 1, marks a two-word instruction.

Ports:
clk  in  1  clock, all state updates on the rising edge.
reset  in  1  synchronous, active-low reset.
stall  in  1  freeze PC, FSM and output registers.
flush  in  1  squash the output packet and abort a partly fetched pair.
redirect  in  1  load PC from redirect_pc (branch, jump, interrupt).
redirect_pc  in  ADDR_W  redirect target.
imem_we  in  1  instruction-memory write enable.
imem_waddr  in  DEPTH_LOG2  write address.
imem_wdata  in  INSTR_W  write data.
out_valid  out  1  IF/ID packet is valid.
instruction  out  INSTR_W  first word of the instruction, or NOP_WORD.
immediate  out  INSTR_W  second word when has_imm is 1, else 0.
has_imm  out  1  packet carries an immediate.
pc_plus_n  out  ADDR_W  address following the last word of the packet.

Behaviour:
- Memory: internal array of 2^DEPTH_LOG2 x INSTR_W. The read is combinational at index pc[DEPTH_LOG2-1:0]. The write is synchronous. A write and a fetch to the same address in the same cycle: the fetch returns the old data.
- Reset (reset=0 at a clock edge) sets:
  - pc=RESET_VECTOR, state=FETCH, hold=0.
  - out_valid=0, instruction=NOP_WORD, immediate=0, has_imm=0, pc_plus_n=0.
  - Reset applied mid-pair discards the held word.
- Priority per edge: reset > redirect > flush > stall > normal fetch.
- FETCH state, word w=mem[pc]:
  - If w[IMM_BIT]=0: single-word packet. out_valid=1, instruction=w, immediate=0, has_imm=0, pc_plus_n=pc+1, pc<=pc+1.
  - If w[IMM_BIT]=1: hold<=w, hold_pc<=pc, pc<=pc+1, state<=FETCH_IMM. Outputs become out_valid=0, instruction=NOP_WORD (one-cycle bubble).
- FETCH_IMM state: out_valid=1, instruction=hold, immediate=mem[pc], has_imm=1, pc_plus_n=pc+1. Then pc<=pc+1 and state<=FETCH. The immediate word is never tested for IMM_BIT.
- Latency: a single-word instruction appears one cycle after its PC is presented. A two-word instruction appears two cycles after its first word's PC.
- stall=1: pc, state, hold and all outputs keep their values. The memory write port stays active.
- flush=1 (no redirect):
  - Outputs become out_valid=0, instruction=NOP_WORD, immediate=0, has_imm=0.
  - In FETCH, pc is unchanged, so the current word is refetched.
  - In FETCH_IMM, pc<=hold_pc and state<=FETCH, so the pair is refetched from its first word.
- redirect=1: pc<=redirect_pc, state<=FETCH, hold discarded. Outputs squashed as for flush. It overrides a simultaneous stall and flush.
- Arithmetic: PC increments modulo 2^ADDR_W. Memory indexing uses only the low DEPTH_LOG2 bits, so it wraps. A pair whose first word sits at the last memory entry takes its immediate from entry 0.
- No combinational path from any input to any output.

Test Plan:
1. Reset low for 2 cycles, then high, with mem[32]=16'h1234 -> during reset out_valid=0, instruction=16'h4000. First edge after release: out_valid=1, instruction=16'h1234, pc_plus_n=33.
2. mem[32]=16'h8001, mem[33]=16'hBEEF, mem[34]=16'h0002 -> cycle 1: out_valid=0. Cycle 2: instruction=16'h8001, immediate=16'hBEEF, has_imm=1, pc_plus_n=34. Cycle 3: instruction=16'h0002, has_imm=0.
3. stall=1 for 3 cycles in FETCH_IMM of the pair in test 2 -> outputs and pc frozen. After release the packet is 8001/BEEF with no words lost or duplicated.
4. redirect=1, redirect_pc=100, with stall=1 and flush=1 in the same cycle -> next edge out_valid=0. The following edge presents mem[100].
5. flush=1 in FETCH_IMM of a pair at address 40 -> out_valid=0. The pair is refetched from 40 and delivered two cycles later with has_imm=1.
6. DEPTH_LOG2=4, redirect_pc=15, mem[15]=16'h8000, mem[0]=16'h00AA -> packet immediate=16'h00AA, pc_plus_n=17. Also: an imem write to the address being fetched in the same cycle returns the old word in that cycle and the new word on refetch.
